axis_ramp_gen: RTL and testbench

- Synthesizable AXI-stream video frame transmitter that drives the 64-bit line-trimming input interface.
- Produces a per-row horizontal ramp pattern with SOF/SOL/EOL/EOF tuser sync codes and tlast on the final beat of each row.
- Serves as the in-system source for crop/scale/reverse consumers, replacing bench-only stimulus on hardware.
- Configuration is latched at frame start. One frame is sent per start pulse.

---
 rtl/axis_ramp_gen.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axis_ramp_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ramp_gen.sv
// AXI-stream video frame source: one frame of a per-row horizontal byte ramp per start pulse,
// with SOF/SOL/EOL/EOF sync codes in tuser and tlast on the final beat of each row.
module axis_ramp_gen #(
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_GAP_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     aclk_reset_n,
    input  logic                     aclk_start,
    input  logic [1:0]               aclk_pixel_width,
    input  logic [12:0]              aclk_x_size,
    input  logic [11:0]              aclk_y_size,
    input  logic [MAX_GAP_WIDTH-1:0] aclk_line_gap,
    output logic                     aclk_busy,
    output logic                     aclk_cfg_err,
    output logic                     aclk_frame_done,
    input  logic                     aclk_tready,
    output logic                     aclk_tvalid,
    output logic [DATA_WIDTH-1:0]    aclk_tdata,
    output logic [3:0]               aclk_tuser,
    output logic                     aclk_tlast
);

    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Byte i of a beat carries the low byte of the pixel covering that byte offset; padding is zero.
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [12:0] beat,
                                                        input logic [1:0]  pw_code,
                                                        input logic [15:0] total_bytes);
        logic [DATA_WIDTH-1:0] d;
        logic [15:0]           off;
        d = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < BYTES; i++) begin
            off = {beat, 3'b000} + 16'(i);
            if (off < total_bytes) begin
                d[i*8 +: 8] = 8'(off >> pw_code);
            end else begin
                d[i*8 +: 8] = 8'd0;
            end
        end
        return d;
    endfunction

    state_t                   state_r, state_s;
    logic [12:0]              beat_r, beat_s;
    logic [11:0]              row_r, row_s;
    logic [MAX_GAP_WIDTH-1:0] gap_r, gap_s;

    logic [1:0]               pw_code_r;
    logic [15:0]              total_r;
    logic [12:0]              beats_r;
    logic [11:0]              y_size_r;
    logic [MAX_GAP_WIDTH-1:0] gap_cfg_r;

    logic [15:0]              start_total_s;
    logic [15:0]              start_sum_s;
    logic [12:0]              start_beats_s;
    logic                     cfg_ok_s;

    logic                     accept_s;
    logic                     last_beat_s;
    logic                     last_row_s;
    logic                     load_s;
    logic                     drop_s;
    logic                     done_s;
    logic                     take_start_s;
    logic                     reject_s;

    logic [1:0]               eff_pw_s;
    logic [15:0]              eff_total_s;
    logic [12:0]              eff_beats_s;
    logic [11:0]              eff_y_s;

    logic                     tvalid_s, busy_s, cfg_err_s;
    logic [DATA_WIDTH-1:0]    tdata_s;
    logic [3:0]               tuser_s;
    logic                     tlast_s;

    // Derive beat count of the requested frame and decide whether it is legal.
    always_comb begin
        start_total_s = {3'b000, aclk_x_size} << aclk_pixel_width;
        start_sum_s   = start_total_s + 16'd7;
        start_beats_s = 13'(start_sum_s >> 3);
        cfg_ok_s      = (start_beats_s >= 13'd2) && (aclk_x_size != 13'd0) && (aclk_y_size != 12'd0);
    end

    assign accept_s    = aclk_tvalid & aclk_tready;
    assign last_beat_s = (beat_r == (beats_r - 13'd1));
    assign last_row_s  = (row_r == (y_size_r - 12'd1));

    // State, beat/row/gap counters and frame configuration latched at accepted start.
    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            state_r   <= ST_IDLE;
            beat_r    <= 13'd0;
            row_r     <= 12'd0;
            gap_r     <= {MAX_GAP_WIDTH{1'b0}};
            pw_code_r <= 2'd0;
            total_r   <= 16'd0;
            beats_r   <= 13'd0;
            y_size_r  <= 12'd0;
            gap_cfg_r <= {MAX_GAP_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            row_r   <= row_s;
            gap_r   <= gap_s;
            if (take_start_s) begin
                pw_code_r <= aclk_pixel_width;
                total_r   <= start_total_s;
                beats_r   <= start_beats_s;
                y_size_r  <= aclk_y_size;
                gap_cfg_r <= aclk_line_gap;
            end else begin
                pw_code_r <= pw_code_r;
                total_r   <= total_r;
                beats_r   <= beats_r;
                y_size_r  <= y_size_r;
                gap_cfg_r <= gap_cfg_r;
            end
        end
    end

    // Next-state logic; load_s means a new beat is presented in the following cycle.
    always_comb begin
        state_s      = state_r;
        beat_s       = beat_r;
        row_s        = row_r;
        gap_s        = gap_r;
        load_s       = 1'b0;
        drop_s       = 1'b0;
        done_s       = 1'b0;
        take_start_s = 1'b0;
        reject_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (aclk_start) begin
                    if (cfg_ok_s) begin
                        state_s      = ST_ACTIVE;
                        beat_s       = 13'd0;
                        row_s        = 12'd0;
                        load_s       = 1'b1;
                        take_start_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (accept_s) begin
                    if (!last_beat_s) begin
                        beat_s = beat_r + 13'd1;
                        load_s = 1'b1;
                    end else if (last_row_s) begin
                        state_s = ST_IDLE;
                        drop_s  = 1'b1;
                        done_s  = 1'b1;
                    end else if (gap_cfg_r != {MAX_GAP_WIDTH{1'b0}}) begin
                        state_s = ST_GAP;
                        gap_s   = gap_cfg_r - {{(MAX_GAP_WIDTH-1){1'b0}}, 1'b1};
                        drop_s  = 1'b1;
                    end else begin
                        beat_s = 13'd0;
                        row_s  = row_r + 12'd1;
                        load_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_GAP: begin
                if (gap_r == {MAX_GAP_WIDTH{1'b0}}) begin
                    state_s = ST_ACTIVE;
                    beat_s  = 13'd0;
                    row_s   = row_r + 12'd1;
                    load_s  = 1'b1;
                end else begin
                    gap_s = gap_r - {{(MAX_GAP_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next output values; the first beat of a frame is built from the incoming configuration.
    always_comb begin
        if (state_r == ST_IDLE) begin
            eff_pw_s    = aclk_pixel_width;
            eff_total_s = start_total_s;
            eff_beats_s = start_beats_s;
            eff_y_s     = aclk_y_size;
        end else begin
            eff_pw_s    = pw_code_r;
            eff_total_s = total_r;
            eff_beats_s = beats_r;
            eff_y_s     = y_size_r;
        end
        tdata_s = aclk_tdata;
        tuser_s = aclk_tuser;
        tlast_s = aclk_tlast;
        if (load_s) begin
            tdata_s = beat_data(beat_s, eff_pw_s, eff_total_s);
            tlast_s = (beat_s == (eff_beats_s - 13'd1));
            if (beat_s == 13'd0) begin
                tuser_s = (row_s == 12'd0) ? 4'b0001 : 4'b0100;
            end else if (tlast_s) begin
                tuser_s = (row_s == (eff_y_s - 12'd1)) ? 4'b0010 : 4'b1000;
            end else begin
                tuser_s = 4'b0000;
            end
        end else begin
            tdata_s = aclk_tdata;
        end
        if (load_s) begin
            tvalid_s = 1'b1;
        end else if (drop_s) begin
            tvalid_s = 1'b0;
        end else begin
            tvalid_s = aclk_tvalid;
        end
        if (take_start_s) begin
            busy_s = 1'b1;
        end else if (done_s) begin
            busy_s = 1'b0;
        end else begin
            busy_s = aclk_busy;
        end
        if (take_start_s) begin
            cfg_err_s = 1'b0;
        end else if (reject_s) begin
            cfg_err_s = 1'b1;
        end else begin
            cfg_err_s = aclk_cfg_err;
        end
    end

    // Output registers.
    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            aclk_tvalid     <= 1'b0;
            aclk_tdata      <= {DATA_WIDTH{1'b0}};
            aclk_tuser      <= 4'b0000;
            aclk_tlast      <= 1'b0;
            aclk_busy       <= 1'b0;
            aclk_cfg_err    <= 1'b0;
            aclk_frame_done <= 1'b0;
        end else begin
            aclk_tvalid     <= tvalid_s;
            aclk_tdata      <= tdata_s;
            aclk_tuser      <= tuser_s;
            aclk_tlast      <= tlast_s;
            aclk_busy       <= busy_s;
            aclk_cfg_err    <= cfg_err_s;
            aclk_frame_done <= done_s;
        end
    end

endmodule

// File: tb/tb_axis_ramp_gen.sv
// Scoreboard bench for axis_ramp_gen: a frame model fills the expected-beat queue at each start,
// an independent monitor pops and compares on every accepted beat.
module tb_axis_ramp_gen;

    logic        aclk = 1'b0;
    logic        aclk_reset_n = 1'b0;
    logic        aclk_start = 1'b0;
    logic [1:0]  aclk_pixel_width = 2'd0;
    logic [12:0] aclk_x_size = 13'd0;
    logic [11:0] aclk_y_size = 12'd0;
    logic [7:0]  aclk_line_gap = 8'd0;
    logic        aclk_busy, aclk_cfg_err, aclk_frame_done;
    logic        aclk_tready = 1'b1;
    logic        aclk_tvalid;
    logic [63:0] aclk_tdata;
    logic [3:0]  aclk_tuser;
    logic        aclk_tlast;

    axis_ramp_gen #(.DATA_WIDTH(64), .MAX_GAP_WIDTH(8)) dut (
        .aclk(aclk), .aclk_reset_n(aclk_reset_n), .aclk_start(aclk_start),
        .aclk_pixel_width(aclk_pixel_width), .aclk_x_size(aclk_x_size),
        .aclk_y_size(aclk_y_size), .aclk_line_gap(aclk_line_gap),
        .aclk_busy(aclk_busy), .aclk_cfg_err(aclk_cfg_err), .aclk_frame_done(aclk_frame_done),
        .aclk_tready(aclk_tready), .aclk_tvalid(aclk_tvalid), .aclk_tdata(aclk_tdata),
        .aclk_tuser(aclk_tuser), .aclk_tlast(aclk_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  user;
        logic        last;
        int          gap;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    int    tr_mode = 0;
    bit    mon_reset = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cfg_legal(input int code, input int x, input int y);
        int beats;
        beats = (x * (1 << code) + 7) / 8;
        return (x > 0) && (y > 0) && (beats >= 2);
    endfunction

    // Reference model: build one row as a byte array, then slice it into 8-byte beats per row.
    task automatic push_frame(input int code, input int x, input int y, input int gap);
        int pw, total, beats;
        logic [7:0] rb[$];
        beat_t e;
        pw = 1 << code;
        total = x * pw;
        beats = (total + 7) / 8;
        for (int k = 0; k < beats * 8; k++) begin
            if (k < total) rb.push_back(8'((k / pw) % 256));
            else rb.push_back(8'd0);
        end
        for (int r = 0; r < y; r++) begin
            for (int b = 0; b < beats; b++) begin
                for (int i = 0; i < 8; i++) e.data[i*8 +: 8] = rb[b*8 + i];
                e.last = (b == beats - 1);
                if (b == 0) e.user = (r == 0) ? 4'b0001 : 4'b0100;
                else if (b == beats - 1) e.user = (r == y - 1) ? 4'b0010 : 4'b1000;
                else e.user = 4'b0000;
                e.gap = (b == 0) ? ((r == 0) ? -1 : gap) : 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Downstream ready pattern, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (tr_mode)
                0: aclk_tready = 1'b1;
                1: aclk_tready = ~aclk_tready;
                default: aclk_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: sampled mid-cycle; checks hold-while-stalled, beat content and inter-row idle cycles.
    logic [63:0] held_d;
    logic [3:0]  held_u;
    logic        held_l;
    bit          prev_stall = 1'b0;
    int          idle = 0;
    always @(negedge aclk) begin
        beat_t e;
        if (mon_reset) begin
            prev_stall = 1'b0;
            idle = 0;
        end else begin
            if (aclk_frame_done) done_cnt++;
            if (prev_stall) begin
                chk("hold_valid", 64'(aclk_tvalid), 64'd1);
                chk("hold_beat", {aclk_tdata}, held_d);
                chk("hold_user_last", {59'd0, aclk_tuser, aclk_tlast}, {59'd0, held_u, held_l});
            end
            if (aclk_tvalid && exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got tvalid=1 data 0x%0h expected no beat", aclk_tdata);
            end else if (aclk_tvalid && aclk_tready) begin
                e = exp_q.pop_front();
                chk("beat_data", aclk_tdata, e.data);
                chk("beat_tuser", 64'(aclk_tuser), 64'(e.user));
                chk("beat_tlast", 64'(aclk_tlast), 64'(e.last));
                if (e.gap >= 0) chk("row_gap", 64'(idle), 64'(e.gap));
            end
            if (aclk_tvalid && aclk_tready) idle = 0;
            else if (!aclk_tvalid) idle++;
            prev_stall = aclk_tvalid && !aclk_tready;
            held_d = aclk_tdata;
            held_u = aclk_tuser;
            held_l = aclk_tlast;
        end
    end

    task automatic pulse_start(input int code, input int x, input int y, input int gap);
        @(posedge aclk);
        #1;
        aclk_pixel_width = 2'(code);
        aclk_x_size = 13'(x);
        aclk_y_size = 12'(y);
        aclk_line_gap = 8'(gap);
        aclk_start = 1'b1;
        @(posedge aclk);
        #1;
        aclk_start = 1'b0;
        aclk_pixel_width = 2'($urandom);
        aclk_x_size = 13'($urandom);
        aclk_y_size = 12'($urandom);
        aclk_line_gap = 8'($urandom);
    endtask

    task automatic run_frame(input int code, input int x, input int y, input int gap, input bit midstart);
        bit legal;
        int budget, d0, cyc;
        legal = cfg_legal(code, x, y);
        d0 = done_cnt;
        if (legal) push_frame(code, x, y, gap);
        pulse_start(code, x, y, gap);
        chk("busy_after_start", 64'(aclk_busy), 64'(legal));
        chk("cfg_err_after_start", 64'(aclk_cfg_err), 64'(!legal));
        if (legal) begin
            budget = ((x * (1 << code) + 7) / 8) * y * 8 + y * (gap + 3) + 50;
            cyc = 0;
            while (aclk_busy && cyc < budget) begin
                aclk_start = (midstart && cyc == 20);
                @(posedge aclk);
                #1;
                cyc++;
            end
            aclk_start = 1'b0;
            chk("frame_timeout", 64'(aclk_busy), 64'd0);
            @(negedge aclk);
            #1;
            chk("frame_done_count", 64'(done_cnt - d0), 64'd1);
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
        end else begin
            repeat (6) @(posedge aclk);
            #1;
            chk("reject_busy", 64'(aclk_busy), 64'd0);
            chk("reject_no_done", 64'(done_cnt - d0), 64'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int code, x, y, gap;
        #23;
        chk("rst_tvalid", 64'(aclk_tvalid), 64'd0);
        chk("rst_busy", 64'(aclk_busy), 64'd0);
        chk("rst_cfg_err", 64'(aclk_cfg_err), 64'd0);
        chk("rst_frame_done", 64'(aclk_frame_done), 64'd0);
        chk("rst_tdata", aclk_tdata, 64'd0);
        chk("rst_tuser_tlast", {59'd0, aclk_tuser, aclk_tlast}, 64'd0);
        @(posedge aclk);
        #2;
        aclk_reset_n = 1'b1;
        mon_reset = 1'b0;

        tr_mode = 0;
        run_frame(2, 256, 4, 0, 1'b0);
        run_frame(0, 20, 2, 0, 1'b0);
        tr_mode = 1;
        run_frame(2, 256, 4, 0, 1'b0);
        tr_mode = 0;
        run_frame(0, 20, 3, 5, 1'b0);

        run_frame(0, 4, 2, 0, 1'b0);
        run_frame(1, 0, 2, 0, 1'b0);
        run_frame(1, 30, 0, 0, 1'b0);
        run_frame(1, 30, 2, 2, 1'b1);

        push_frame(2, 256, 4, 0);
        pulse_start(2, 256, 4, 0);
        repeat (150) @(posedge aclk);
        #2;
        mon_reset = 1'b1;
        aclk_reset_n = 1'b0;
        #1;
        chk("async_rst_tvalid", 64'(aclk_tvalid), 64'd0);
        chk("async_rst_busy", 64'(aclk_busy), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge aclk);
        #2;
        aclk_reset_n = 1'b1;
        mon_reset = 1'b0;
        run_frame(2, 256, 2, 0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            code = $urandom_range(0, 3);
            x = $urandom_range(1, 40);
            y = $urandom_range(0, 4);
            gap = $urandom_range(0, 6);
            tr_mode = $urandom_range(0, 2);
            run_frame(code, x, y, gap, (n == 3));
        end
        tr_mode = 0;
        repeat (5) @(posedge aclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
